// File: rtl/regfile_pkg.sv
// Shared types and sizing for the 8x4 register file and its sequencing master.
package regfile_pkg;

  localparam int unsigned RF_DEPTH  = 8;
  localparam int unsigned RF_ADDR_W = $clog2(RF_DEPTH);
  localparam int unsigned RF_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DUMP = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  typedef enum logic {
    OP_FILL = 1'b0,
    OP_DUMP = 1'b1
  } seq_op_t;

endpackage

// File: rtl/regfile_seq_ctrl_addr_counter.sv
// Entry pointer: sync clear, increment, and a flag for the final entry.
// Incrementing on the final entry returns to zero, so a sweep never runs past DEPTH-1.
module addr_counter #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == ADDR_W'(DEPTH - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = last_o ? '0 : cnt_q + ADDR_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/regfile_seq_ctrl.sv
// Sequencing master for the register file: FILL writes DEPTH words from the
// input stream into entries 0..DEPTH-1, DUMP streams the same entries out.
module regfile_seq_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH  = RF_DEPTH,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cmd_valid,
  input  logic              cmd_op,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_din,
  output logic              rf_load,
  input  logic [DATA_W-1:0] rf_q,
  output logic              busy,
  output logic              done
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr;
  logic              ptr_last, ptr_clr, ptr_inc;

  // Pointer is held at zero whenever idle, so every accepted command starts at entry 0.
  assign ptr_clr = clr || (state_q == IDLE);

  addr_counter #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ptr (
    .clk_i (clk),
    .clr_i (ptr_clr),
    .inc_i (ptr_inc),
    .cnt_o (ptr),
    .last_o(ptr_last)
  );

  assign rf_din   = in_data;
  assign out_data = rf_q;

  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rf_load   = 1'b0;
    rf_addr   = '0;
    busy      = 1'b0;
    done      = 1'b0;
    ptr_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = (seq_op_t'(cmd_op) == OP_DUMP) ? DUMP : FILL;
      end
      FILL: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        rf_addr  = ptr;
        rf_load  = in_valid;
        ptr_inc  = in_valid;
        if (in_valid && ptr_last) state_d = DONE;
      end
      DUMP: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        rf_addr   = ptr;
        ptr_inc   = out_ready;
        if (out_ready && ptr_last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Randomized bench for regfile_seq_ctrl driving a behavioural 8x4 register file,
// checked against a transaction-level model of the expected entry contents.
module tb_regfile_seq_ctrl;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned BUDGET = 200;

  logic              clk = 1'b0;
  logic              clr = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_op = 1'b0;
  logic              cmd_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_din;
  logic              rf_load;
  logic [DATA_W-1:0] rf_q;
  logic              busy;
  logic              done;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Register file attached to the controller, and the bench's own view of what it should hold.
  logic [DATA_W-1:0] rf_mem  [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  assign rf_q = rf_mem[rf_addr];
  always @(posedge clk) if (rf_load) rf_mem[rf_addr] <= rf_din;

  regfile_seq_ctrl #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_ready(cmd_ready),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .rf_addr  (rf_addr),
    .rf_din   (rf_din),
    .rf_load  (rf_load),
    .rf_q     (rf_q),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_rf_load"},   32'(rf_load),   32'd0);
    check({tag, "_rf_addr"},   32'(rf_addr),   32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset(input int unsigned cycles);
    @(negedge clk);
    clr = 1'b1; cmd_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    for (int unsigned i = 0; i < cycles; i++) @(negedge clk);
    #1 check_idle("reset");
    clr = 1'b0;
  endtask

  // Present a command while idle; the controller must be ready for it.
  task automatic issue(input logic op);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op;
    #1 check("issue_cmd_ready", 32'(cmd_ready), 32'd1);
    check("issue_busy", 32'(busy), 32'd0);
  endtask

  // After the last transfer: one done cycle, then idle.
  task automatic expect_done(input string tag);
    @(negedge clk);
    cmd_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1 check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done_cmd_ready"}, 32'(cmd_ready), 32'd0);
    @(negedge clk);
    #1 check({tag, "_done_once"}, 32'(done), 32'd0);
    check({tag, "_ready_again"}, 32'(cmd_ready), 32'd1);
  endtask

  // valid_pct: chance (percent) that in_valid is offered each cycle.
  // stop_after: abort with clr after this many writes (DEPTH = full command).
  task automatic run_fill(input logic [DATA_W-1:0] data [DEPTH], input int unsigned valid_pct,
                          input int unsigned stop_after);
    int unsigned k = 0;
    int unsigned cyc = 0;
    issue(1'b0);
    while (k < stop_after && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(1, 100) <= valid_pct) ? 1'b1 : 1'b0;
      in_data   = in_valid ? data[k] : DATA_W'($urandom);
      #1 check("fill_busy", 32'(busy), 32'd1);
      check("fill_in_ready", 32'(in_ready), 32'd1);
      check("fill_cmd_ready", 32'(cmd_ready), 32'd0);
      check("fill_rf_load", 32'(rf_load), 32'(in_valid));
      check("fill_rf_addr", 32'(rf_addr), k);
      if (in_valid) begin
        check("fill_rf_din", 32'(rf_din), 32'(data[k]));
        ref_mem[k] = data[k];
        k++;
      end
    end
    if (cyc >= BUDGET) check("fill_timeout", k, stop_after);
    if (stop_after >= DEPTH) expect_done("fill");
  endtask

  // mode 0: out_ready always 1; mode 1: pattern 1,0,0 repeating; mode 2: random.
  task automatic run_dump(input int unsigned mode);
    int unsigned k = 0;
    int unsigned cyc = 0;
    issue(1'b1);
    while (k < DEPTH && cyc < BUDGET) begin
      @(negedge clk);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0) ? 1'b1 : 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      cyc++;
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 1'($urandom_range(0, 1));
      #1 check("dump_busy", 32'(busy), 32'd1);
      check("dump_out_valid", 32'(out_valid), 32'd1);
      check("dump_rf_load", 32'(rf_load), 32'd0);
      check("dump_rf_addr", 32'(rf_addr), k);
      check("dump_out_data", 32'(out_data), 32'(ref_mem[k]));
      if (out_ready) k++;
    end
    if (cyc >= BUDGET) check("dump_timeout", k, DEPTH);
    expect_done("dump");
  endtask

  logic [DATA_W-1:0] pat [DEPTH];

  initial begin
    do_reset(2);

    pat = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6};
    run_fill(pat, 100, DEPTH);
    run_dump(0);
    run_dump(1);

    for (int unsigned i = 0; i < DEPTH; i++) pat[i] = DATA_W'($urandom);
    run_fill(pat, 50, DEPTH);
    run_dump(2);

    // Abort a fill after three writes; later entries must keep their old contents.
    pat = '{4'hA, 4'hB, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    run_fill(pat, 100, 3);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    #1 check_idle("abort");
    @(negedge clk);
    #1 check("abort_no_done", 32'(done), 32'd0);
    run_dump(0);

    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned i = 0; i < DEPTH; i++) pat[i] = DATA_W'($urandom);
      run_fill(pat, $urandom_range(30, 100), DEPTH);
      run_dump(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
